// File: rtl/c2c_pkg.sv
// Shared constants, command encodings and FSM states for the address-translation CAM.
package c2c_pkg;

  localparam int unsigned PAGE_W_DEF      = 4;
  localparam int unsigned PID_W_DEF       = 4;
  localparam int unsigned ENTRIES_DEF     = 8;
  localparam int unsigned STAGE_DEPTH_DEF = 32;
  localparam int unsigned DATA_W_DEF      = 2 * PAGE_W_DEF;
  localparam int unsigned CMD_W           = 3;

  localparam logic [CMD_W-1:0] CMD_NOP       = 3'b000;
  localparam logic [CMD_W-1:0] CMD_WRITE     = 3'b001;
  localparam logic [CMD_W-1:0] CMD_LOAD      = 3'b010;
  localparam logic [CMD_W-1:0] CMD_XLATE     = 3'b011;
  localparam logic [CMD_W-1:0] CMD_FLUSH_PID = 3'b100;
  localparam logic [CMD_W-1:0] CMD_FLUSH_ALL = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XLATE = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // Index width that stays at least one bit for single-element arrays.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/c2c_xlate_cam_cam.sv
// PID-tagged translation CAM: match/free search, victim pointer, write and flush ports.
module c2c_cam
  import c2c_pkg::*;
#(
  parameter int unsigned PAGE_W  = PAGE_W_DEF,
  parameter int unsigned PID_W   = PID_W_DEF,
  parameter int unsigned ENTRIES = ENTRIES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PID_W-1:0]  key_pid_i,
  input  logic [PAGE_W-1:0] key_vpn_i,
  output logic              hit_c,
  output logic [PAGE_W-1:0] hit_ppn_c,
  input  logic              wr_en_i,
  input  logic [PAGE_W-1:0] wr_ppn_i,
  input  logic              flush_pid_i,
  input  logic              flush_all_i,
  input  logic [PID_W-1:0]  flush_tag_i
);

  localparam int unsigned IDX_W = idx_w(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [PID_W-1:0]   pid_q [ENTRIES];
  logic [PAGE_W-1:0]  vpn_q [ENTRIES];
  logic [PAGE_W-1:0]  ppn_q [ENTRIES];
  logic [IDX_W-1:0]   victim_q;

  logic [ENTRIES-1:0] match_c;
  logic [IDX_W-1:0]   hit_idx_c;
  logic               free_c;
  logic [IDX_W-1:0]   free_idx_c;
  logic [IDX_W-1:0]   wr_idx_c;
  logic               use_victim_c;

  // At most one entry matches, so OR-ing the matching indices yields the hit index.
  always_comb begin
    match_c    = '0;
    hit_idx_c  = '0;
    hit_ppn_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_c[i] = valid_q[i] && (pid_q[i] == key_pid_i) && (vpn_q[i] == key_vpn_i);
      if (match_c[i]) begin
        hit_idx_c = hit_idx_c | IDX_W'(i);
        hit_ppn_c = hit_ppn_c | ppn_q[i];
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
    hit_c = |match_c;
  end

  always_comb begin
    use_victim_c = 1'b0;
    if (hit_c) begin
      wr_idx_c = hit_idx_c;
    end else if (free_c) begin
      wr_idx_c = free_idx_c;
    end else begin
      wr_idx_c     = victim_q;
      use_victim_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else if (flush_all_i) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else begin
      if (flush_pid_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (pid_q[i] == flush_tag_i) valid_q[i] <= 1'b0;
        end
      end
      if (wr_en_i) begin
        valid_q[wr_idx_c] <= 1'b1;
        if (use_victim_c) begin
          victim_q <= (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + IDX_W'(1);
        end
      end
    end
  end

  // Tag/payload storage needs no reset: entries are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      pid_q[wr_idx_c] <= key_pid_i;
      vpn_q[wr_idx_c] <= key_vpn_i;
      ppn_q[wr_idx_c] <= wr_ppn_i;
    end
  end

endmodule

// File: rtl/c2c_xlate_cam.sv
// Address-translation top: command FSM, staging buffer and registered translate outputs.
module c2c_xlate_cam
  import c2c_pkg::*;
#(
  parameter int unsigned PAGE_W      = PAGE_W_DEF,
  parameter int unsigned PID_W       = PID_W_DEF,
  parameter int unsigned ENTRIES     = ENTRIES_DEF,
  parameter int unsigned STAGE_DEPTH = STAGE_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CMD_W-1:0]      cmd,
  input  logic [2*PAGE_W-1:0]   datain,
  input  logic                  datavalid,
  input  logic [PID_W-1:0]      PID,
  output logic [2*PAGE_W-1:0]   dataout,
  output logic                  outvalid,
  output logic                  pagefault,
  output logic                  busy,
  output logic                  wd
);

  localparam int unsigned DATA_W = 2 * PAGE_W;
  localparam int unsigned WORD_W = PID_W + DATA_W;
  localparam int unsigned PTR_W  = $clog2(STAGE_DEPTH + 1);
  localparam int unsigned SIDX_W = idx_w(STAGE_DEPTH);

  logic [WORD_W-1:0] stage_mem [STAGE_DEPTH];

  state_e             state_q,     state_d;
  logic [PTR_W-1:0]   wptr_q,      wptr_d;
  logic [SIDX_W-1:0]  rptr_q,      rptr_d;
  logic               wd_q,        wd_d;
  logic [PID_W-1:0]   xpid_q,      xpid_d;
  logic [DATA_W-1:0]  xdata_q,     xdata_d;
  logic               fall_q,      fall_d;
  logic [DATA_W-1:0]  dataout_q,   dataout_d;
  logic               outvalid_q,  outvalid_d;
  logic               pagefault_q, pagefault_d;
  logic               busy_q,      busy_d;

  logic               stage_we_c;
  logic [WORD_W-1:0]  ld_word_c;
  logic [PID_W-1:0]   key_pid_c;
  logic [PAGE_W-1:0]  key_vpn_c;
  logic               cam_wr_c;
  logic               flush_pid_c;
  logic               flush_all_c;
  logic               hit_c;
  logic [PAGE_W-1:0]  hit_ppn_c;

  assign ld_word_c = stage_mem[rptr_q];

  c2c_cam #(
    .PAGE_W  (PAGE_W),
    .PID_W   (PID_W),
    .ENTRIES (ENTRIES)
  ) u_cam (
    .clk         (clk),
    .rst         (rst),
    .key_pid_i   (key_pid_c),
    .key_vpn_i   (key_vpn_c),
    .hit_c       (hit_c),
    .hit_ppn_c   (hit_ppn_c),
    .wr_en_i     (cam_wr_c),
    .wr_ppn_i    (ld_word_c[PAGE_W-1:0]),
    .flush_pid_i (flush_pid_c),
    .flush_all_i (flush_all_c),
    .flush_tag_i (xpid_q)
  );

  // Next-state and output decode; the CAM key follows the staging word during LOAD.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    wd_d        = wd_q;
    xpid_d      = xpid_q;
    xdata_d     = xdata_q;
    fall_d      = fall_q;
    dataout_d   = dataout_q;
    outvalid_d  = 1'b0;
    pagefault_d = 1'b0;
    stage_we_c  = 1'b0;
    cam_wr_c    = 1'b0;
    flush_pid_c = 1'b0;
    flush_all_c = 1'b0;
    key_pid_c   = xpid_q;
    key_vpn_c   = xdata_q[DATA_W-1:PAGE_W];

    case (state_q)
      ST_IDLE: begin
        case (cmd)
          CMD_WRITE: begin
            state_d = ST_WRITE;
            wptr_d  = '0;
            wd_d    = 1'b0;
          end
          CMD_LOAD: begin
            if (wd_q) begin
              state_d = ST_LOAD;
              rptr_d  = '0;
            end
          end
          CMD_XLATE: begin
            state_d = ST_XLATE;
            xpid_d  = PID;
            xdata_d = datain;
          end
          CMD_FLUSH_PID: begin
            state_d = ST_FLUSH;
            xpid_d  = PID;
            fall_d  = 1'b0;
          end
          CMD_FLUSH_ALL: begin
            state_d = ST_FLUSH;
            fall_d  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_WRITE: begin
        if (cmd == CMD_WRITE) begin
          if (datavalid) begin
            stage_we_c = 1'b1;
            wptr_d     = wptr_q + PTR_W'(1);
            if (wptr_q == PTR_W'(STAGE_DEPTH - 1)) begin
              state_d = ST_IDLE;
              wd_d    = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
          wd_d    = (wptr_q != '0);
        end
      end
      ST_LOAD: begin
        key_pid_c = ld_word_c[WORD_W-1:DATA_W];
        key_vpn_c = ld_word_c[DATA_W-1:PAGE_W];
        cam_wr_c  = 1'b1;
        rptr_d    = rptr_q + SIDX_W'(1);
        if (PTR_W'(rptr_q) == wptr_q - PTR_W'(1)) begin
          state_d = ST_IDLE;
          wd_d    = 1'b0;
          wptr_d  = '0;
        end
      end
      ST_XLATE: begin
        state_d    = ST_IDLE;
        outvalid_d = 1'b1;
        if (hit_c) begin
          dataout_d = {hit_ppn_c, xdata_q[PAGE_W-1:0]};
        end else begin
          dataout_d   = '0;
          pagefault_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        if (fall_q) flush_all_c = 1'b1;
        else        flush_pid_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      wd_q        <= 1'b0;
      xpid_q      <= '0;
      xdata_q     <= '0;
      fall_q      <= 1'b0;
      dataout_q   <= '0;
      outvalid_q  <= 1'b0;
      pagefault_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      wd_q        <= wd_d;
      xpid_q      <= xpid_d;
      xdata_q     <= xdata_d;
      fall_q      <= fall_d;
      dataout_q   <= dataout_d;
      outvalid_q  <= outvalid_d;
      pagefault_q <= pagefault_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stage_we_c) stage_mem[SIDX_W'(wptr_q)] <= {PID, datain};
  end

  assign dataout   = dataout_q;
  assign outvalid  = outvalid_q;
  assign pagefault = pagefault_q;
  assign busy      = busy_q;
  assign wd        = wd_q;

endmodule

// File: tb/tb_c2c_xlate_cam.sv
// Directed self-checking bench for c2c_xlate_cam with default parameters.
module tb_c2c_xlate_cam;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cmd;
  logic [7:0] datain;
  logic       datavalid;
  logic [3:0] PID;
  logic [7:0] dataout;
  logic       outvalid;
  logic       pagefault;
  logic       busy;
  logic       wd;

  int nchk  = 0;
  int npass = 0;

  logic [3:0] wp [0:63];
  logic [7:0] wdv [0:63];

  c2c_xlate_cam dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .datain    (datain),
    .datavalid (datavalid),
    .PID       (PID),
    .dataout   (dataout),
    .outvalid  (outvalid),
    .pagefault (pagefault),
    .busy      (busy),
    .wd        (wd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd = 3'b000; datavalid = 1'b0; datain = 8'h00; PID = 4'h0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic write_session(input int n);
    cmd = 3'b001; datavalid = 1'b0;
    tick;
    for (int i = 0; i < n; i++) begin
      cmd = 3'b001; datavalid = 1'b1; PID = wp[i]; datain = wdv[i];
      tick;
    end
    cmd = 3'b000; datavalid = 1'b0;
    tick;
  endtask

  task automatic load_session(output int cyc);
    cmd = 3'b010;
    tick;
    cmd = 3'b000;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick;
    end
  endtask

  task automatic xlate(input logic [3:0] pid, input logic [7:0] din,
                       output logic ov, output logic pf, output logic [7:0] dout, output logic bz);
    cmd = 3'b011; PID = pid; datain = din;
    tick;
    cmd = 3'b000;
    tick;
    ov = outvalid; pf = pagefault; dout = dataout; bz = busy;
  endtask

  task automatic test_reset;
    do_reset;
    nchk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else npass++;
    nchk++; if (wd !== 1'b0) $display("FAIL reset_wd got %b want 0", wd); else npass++;
    nchk++; if (outvalid !== 1'b0) $display("FAIL reset_outvalid got %b want 0", outvalid); else npass++;
    nchk++; if (pagefault !== 1'b0) $display("FAIL reset_pagefault got %b want 0", pagefault); else npass++;
    nchk++; if (dataout !== 8'h00) $display("FAIL reset_dataout got %h want 00", dataout); else npass++;
  endtask

  task automatic test_basic;
    int cyc;
    logic ov, pf, bz;
    logic [7:0] d;
    wp[0] = 4'h4; wdv[0] = 8'h18;
    wp[1] = 4'h4; wdv[1] = 8'h29;
    wp[2] = 4'h4; wdv[2] = 8'h3A;
    write_session(3);
    nchk++; if (wd !== 1'b1) $display("FAIL basic_wd got %b want 1", wd); else npass++;
    nchk++; if (busy !== 1'b0) $display("FAIL basic_busy_idle got %b want 0", busy); else npass++;
    load_session(cyc);
    nchk++; if (cyc != 3) $display("FAIL basic_load_cycles got %0d want 3", cyc); else npass++;
    nchk++; if (wd !== 1'b0) $display("FAIL basic_wd_after_load got %b want 0", wd); else npass++;
    xlate(4'h4, 8'h2C, ov, pf, d, bz);
    nchk++; if (ov !== 1'b1) $display("FAIL basic_hit_outvalid got %b want 1", ov); else npass++;
    nchk++; if (pf !== 1'b0) $display("FAIL basic_hit_pagefault got %b want 0", pf); else npass++;
    nchk++; if (d !== 8'h9C) $display("FAIL basic_hit_dataout got %h want 9c", d); else npass++;
    nchk++; if (bz !== 1'b0) $display("FAIL basic_busy_with_outvalid got %b want 0", bz); else npass++;
    tick;
    nchk++; if (outvalid !== 1'b0) $display("FAIL basic_outvalid_pulse got %b want 0", outvalid); else npass++;
    nchk++; if (dataout !== 8'h9C) $display("FAIL basic_dataout_hold got %h want 9c", dataout); else npass++;
    xlate(4'h8, 8'h18, ov, pf, d, bz);
    nchk++; if (ov !== 1'b1) $display("FAIL miss_outvalid got %b want 1", ov); else npass++;
    nchk++; if (pf !== 1'b1) $display("FAIL miss_pagefault got %b want 1", pf); else npass++;
    nchk++; if (d !== 8'h00) $display("FAIL miss_dataout got %h want 00", d); else npass++;
  endtask

  task automatic test_update;
    int cyc;
    logic ov, pf, bz;
    logic [7:0] d;
    do_reset;
    wp[0] = 4'h4; wdv[0] = 8'h18;
    write_session(1);
    load_session(cyc);
    wp[0] = 4'h4; wdv[0] = 8'h15;
    write_session(1);
    load_session(cyc);
    nchk++; if (cyc != 1) $display("FAIL update_load_cycles got %0d want 1", cyc); else npass++;
    xlate(4'h4, 8'h13, ov, pf, d, bz);
    nchk++; if (pf !== 1'b0 || d !== 8'h53) $display("FAIL update_xlate got pf=%b %h want pf=0 53", pf, d); else npass++;
  endtask

  task automatic test_replace;
    int cyc;
    logic ov, pf, bz;
    logic [7:0] d;
    do_reset;
    for (int v = 0; v < 10; v++) begin
      wp[v] = 4'h3; wdv[v] = {4'(v), 4'(v + 5)};
    end
    write_session(10);
    load_session(cyc);
    nchk++; if (cyc != 10) $display("FAIL replace_load_cycles got %0d want 10", cyc); else npass++;
    xlate(4'h3, 8'h00, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1) $display("FAIL replace_vpn0_fault got %b want 1", pf); else npass++;
    xlate(4'h3, 8'h10, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1) $display("FAIL replace_vpn1_fault got %b want 1", pf); else npass++;
    xlate(4'h3, 8'h84, ov, pf, d, bz);
    nchk++; if (pf !== 1'b0 || d !== 8'hD4) $display("FAIL replace_vpn8 got pf=%b %h want pf=0 d4", pf, d); else npass++;
    // back-to-back: second XLATE issued in the cycle the first result is valid
    cmd = 3'b011; PID = 4'h3; datain = 8'h21;
    tick;
    cmd = 3'b000;
    tick;
    nchk++; if (outvalid !== 1'b1 || dataout !== 8'h71) $display("FAIL b2b_first got ov=%b %h want ov=1 71", outvalid, dataout); else npass++;
    cmd = 3'b011; PID = 4'h3; datain = 8'h93;
    tick;
    cmd = 3'b000;
    nchk++; if (outvalid !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept got ov=%b busy=%b want ov=0 busy=1", outvalid, busy); else npass++;
    tick;
    nchk++; if (outvalid !== 1'b1 || pagefault !== 1'b0 || dataout !== 8'hE3) $display("FAIL b2b_second got ov=%b pf=%b %h want ov=1 pf=0 e3", outvalid, pagefault, dataout); else npass++;
  endtask

  task automatic test_flush;
    int cyc;
    logic ov, pf, bz;
    logic [7:0] d;
    do_reset;
    wp[0] = 4'h1; wdv[0] = 8'h41;
    wp[1] = 4'h2; wdv[1] = 8'h52;
    write_session(2);
    load_session(cyc);
    cmd = 3'b100; PID = 4'h1;
    tick;
    cmd = 3'b000;
    nchk++; if (busy !== 1'b1) $display("FAIL flush_busy got %b want 1", busy); else npass++;
    tick;
    nchk++; if (busy !== 1'b0) $display("FAIL flush_one_cycle got %b want 0", busy); else npass++;
    xlate(4'h1, 8'h40, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1) $display("FAIL flushpid_pid1_fault got %b want 1", pf); else npass++;
    xlate(4'h2, 8'h50, ov, pf, d, bz);
    nchk++; if (pf !== 1'b0 || d !== 8'h20) $display("FAIL flushpid_pid2_hit got pf=%b %h want pf=0 20", pf, d); else npass++;
    cmd = 3'b101;
    tick;
    cmd = 3'b000;
    tick;
    xlate(4'h2, 8'h50, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1) $display("FAIL flushall_pid2_fault got %b want 1", pf); else npass++;
  endtask

  task automatic test_overflow;
    int cyc;
    logic ov, pf, bz;
    logic [7:0] d;
    do_reset;
    cmd = 3'b001; datavalid = 1'b0;
    tick;
    for (int i = 0; i < 35; i++) begin
      PID = 4'(i >> 4); datain = {4'(i), 4'(i * 3)}; datavalid = 1'b1;
      cmd = (i < 32) ? 3'b001 : 3'b000;
      tick;
      if (i == 30) begin
        nchk++; if (busy !== 1'b1) $display("FAIL ovf_busy_before_full got %b want 1", busy); else npass++;
      end
      if (i == 31) begin
        nchk++; if (busy !== 1'b0 || wd !== 1'b1) $display("FAIL ovf_exit got busy=%b wd=%b want 0 1", busy, wd); else npass++;
      end
    end
    datavalid = 1'b0;
    nchk++; if (wd !== 1'b1) $display("FAIL ovf_wd_held got %b want 1", wd); else npass++;
    load_session(cyc);
    nchk++; if (cyc != 32) $display("FAIL ovf_load_cycles got %0d want 32", cyc); else npass++;
    xlate(4'h1, 8'hF7, ov, pf, d, bz);
    nchk++; if (pf !== 1'b0 || d !== 8'hD7) $display("FAIL ovf_last_word got pf=%b %h want pf=0 d7", pf, d); else npass++;
    xlate(4'h1, 8'h80, ov, pf, d, bz);
    nchk++; if (pf !== 1'b0 || d !== 8'h80) $display("FAIL ovf_word24 got pf=%b %h want pf=0 80", pf, d); else npass++;
    xlate(4'h1, 8'h70, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1) $display("FAIL ovf_word23_evicted got %b want 1", pf); else npass++;
    xlate(4'h2, 8'h01, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1) $display("FAIL ovf_dropped_word got %b want 1", pf); else npass++;
  endtask

  task automatic test_reset_mid_load;
    int cyc;
    logic ov, pf, bz;
    logic [7:0] d;
    do_reset;
    wp[0] = 4'h6; wdv[0] = 8'h12;
    wp[1] = 4'h6; wdv[1] = 8'h23;
    wp[2] = 4'h6; wdv[2] = 8'h34;
    write_session(3);
    load_session(cyc);
    xlate(4'h6, 8'h1F, ov, pf, d, bz);
    nchk++; if (pf !== 1'b0 || d !== 8'h2F) $display("FAIL midload_pre got pf=%b %h want pf=0 2f", pf, d); else npass++;
    wp[0] = 4'h7; wdv[0] = 8'h45;
    wp[1] = 4'h7; wdv[1] = 8'h56;
    wp[2] = 4'h7; wdv[2] = 8'h67;
    write_session(3);
    cmd = 3'b010;
    tick;
    cmd = 3'b000;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    nchk++; if ({busy, wd, outvalid, pagefault} !== 4'b0000) $display("FAIL midload_flags got %b want 0000", {busy, wd, outvalid, pagefault}); else npass++;
    nchk++; if (dataout !== 8'h00) $display("FAIL midload_dataout got %h want 00", dataout); else npass++;
    xlate(4'h6, 8'h1F, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1 || d !== 8'h00) $display("FAIL midload_old_fault got pf=%b %h want pf=1 00", pf, d); else npass++;
    xlate(4'h7, 8'h40, ov, pf, d, bz);
    nchk++; if (pf !== 1'b1) $display("FAIL midload_partial_fault got %b want 1", pf); else npass++;
    cmd = 3'b010;
    tick;
    cmd = 3'b000;
    nchk++; if (busy !== 1'b0) $display("FAIL midload_load_ignored got %b want 0", busy); else npass++;
  endtask

  initial begin
    rst = 1'b1; cmd = 3'b000; datain = 8'h00; datavalid = 1'b0; PID = 4'h0;
    test_reset;
    test_basic;
    test_update;
    test_replace;
    test_flush;
    test_overflow;
    test_reset_mid_load;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/c2c_xlate_cam.md
# c2c_xlate_cam

Parametrised address-translation block, successor to the fixed 8-entry cache-to-CAM translator. The host streams (VPN, PPN) mapping words tagged with a PID into a staging buffer, then loads them into a PID-tagged CAM. Translate requests return the physical address or a page fault. Adds configurable page/CAM/staging sizes, in-place update of duplicate mappings, round-robin replacement when full, and per-PID / global flush.

## Interface
- PAGE_W, 4, VPN/PPN/offset width; data word width DATA_W = 2*PAGE_W (localparam)
- PID_W, 4, process-ID width
- ENTRIES, 8, CAM entries (>=2)
- STAGE_DEPTH, 32, staging-buffer words (>=1)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd  in  3  000 NOP, 001 WRITE, 010 LOAD, 011 XLATE, 100 FLUSH_PID, 101 FLUSH_ALL; 110/111 = NOP
- datain  in  DATA_W  WRITE: {VPN, PPN}; XLATE: {VPN, OFFSET}
- datavalid  in  1  qualifies datain during WRITE
- PID  in  PID_W  tag for WRITE words, XLATE and FLUSH_PID
- dataout  out  DATA_W  {PPN, OFFSET} on hit, 0 on fault
- outvalid  out  1  one-cycle pulse: translate result valid
- pagefault  out  1  one-cycle pulse with outvalid on miss
- busy  out  1  high while not in IDLE
- wd  out  1  level: staging buffer holds a completed write session

## Operation
- FSM states: IDLE, WRITE, LOAD, XLATE, FLUSH. Commands are sampled only in IDLE.
- IDLE, cmd=WRITE -> WRITE. Clears write pointer and wd.
- WRITE: each cycle with cmd=WRITE and datavalid=1 stores {PID, datain} at staging[wptr] and increments wptr.
  - cmd!=WRITE -> IDLE. wd=1 if wptr>0.
  - wptr reaching STAGE_DEPTH -> IDLE with wd=1. Further words are not accepted.
  - datavalid=0 cycles leave state unchanged.
- IDLE, cmd=LOAD: if wd=1 -> LOAD, otherwise ignored.
- LOAD: one staging word per cycle, index 0..wptr-1. For each word:
  - valid entry matching (PID, VPN) exists: overwrite its PPN.
  - else: write the lowest-index invalid entry.
  - else: write the entry at victim pointer, then victim = (victim+1) mod ENTRIES.
  - After the last word: IDLE, wd=0, wptr=0.
- IDLE, cmd=XLATE: register PID and datain -> XLATE. In XLATE, compare against all valid entries and register the result, then -> IDLE.
  - Hit: dataout={PPN, OFFSET}, outvalid=1, pagefault=0.
  - Miss: dataout=0, outvalid=1, pagefault=1.
- FLUSH_PID: clears valid on every entry whose tag equals the registered PID. FLUSH_ALL: clears all valid bits and resets victim to 0. Both take one cycle in FLUSH, then IDLE. Staging buffer and wd are unaffected.
- Duplicates are never created, so at most one entry hits.

## Timing
- Reset (rst=1 at an edge) forces:
  - state IDLE, busy=0, wd=0, outvalid=0, pagefault=0, dataout=0
  - wptr=0, victim=0, all CAM valid bits 0
  - This holds mid-WRITE/LOAD: a partial load is discarded.
- busy rises the cycle after the accepting edge and falls on return to IDLE.
- XLATE latency: command accepted at edge N. busy=1 during cycle N..N+1. Result registered at edge N+1. outvalid/pagefault high for exactly one cycle, during which busy=0. dataout holds until the next XLATE result or reset.
- LOAD occupies exactly wptr cycles. FLUSH occupies 1 cycle.
- A new command may be issued in the same cycle outvalid is high. Back-to-back XLATE throughput is one per 2 cycles.
- WRITE: a word is accepted at the same edge busy rises only if that edge is in WRITE state. The first word is therefore accepted at the edge after the WRITE command.

## Structure
- Package c2c_pkg holds:
  - cmd encodings (CMD_NOP … CMD_FLUSH_ALL)
  - FSM state enum
  - derived localparams (DATA_W, index widths via $clog2)
- Sub-module c2c_cam holds:
  - valid/PID/VPN/PPN arrays
  - combinational match vector and hit index
  - first-free index with any-free flag
  - victim pointer
  - Write/flush ports driven by the top FSM.
- Top holds the FSM, staging buffer and output registers.

## Test plan
- Reset, WRITE 3 words PID=4 ({1,8},{2,9},{3,A}), NOP -> wd=1, busy=0; LOAD -> busy high 3 cycles; XLATE PID=4 datain=0x2C -> outvalid=1, dataout=0x9C, pagefault=0.
- XLATE PID=8 datain=0x18 after the above -> outvalid=1, pagefault=1, dataout=0x00.
- Load PID=4 {1,8}, then reload {1,5} -> single entry; XLATE 0x13 -> 0x53.
- Fill ENTRIES+2 distinct mappings -> entries 0 and 1 replaced in order; oldest two VPNs fault, rest hit.
- Load PID=1 and PID=2 maps, FLUSH_PID PID=1 -> PID=1 lookups fault, PID=2 hit; FLUSH_ALL -> all fault.
- Stream STAGE_DEPTH+3 words -> exit to IDLE at STAGE_DEPTH with wd=1, extra words dropped. Assert rst mid-LOAD -> all outputs 0 and subsequent XLATE faults.
